vga_grid_renderer: RTL and testbench

Consumer end of the flattened 64x48 two-bit cell grid bus produced by the game controller. It generates 640x480@60 Hz VGA timing from the 50 MHz clock, maps each visible pixel to its 10x10-pixel cell, and drives sync and 4-bit RGB.
- The grid is snapshotted into a shadow register once per frame, at vblank start, so a frame never tears.
- It sits between the game controller and the board's VGA pins.

---
 rtl/snake_vga_pkg.sv | 41 ++++
 rtl/vga_grid_renderer_if.sv | 26 ++
 rtl/vga_grid_renderer_timing.sv | 97 +++++++++
 rtl/vga_grid_renderer.sv | 119 +++++++++++
 tb/tb_vga_grid_renderer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/snake_vga_pkg.sv
// Shared timing constants, cell colour codes and the colour lookup
// used by the VGA grid renderer.
package snake_vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int CELL_PX   = 10;
    localparam int GRID_W    = 64;
    localparam int GRID_H    = 48;

    typedef enum logic [1:0] {
        COL_EMPTY = 2'b00,
        COL_RED   = 2'b01,
        COL_GREEN = 2'b10,
        COL_BLUE  = 2'b11
    } cell_col_e;

    localparam logic [11:0] RGB_EMPTY = 12'h000;
    localparam logic [11:0] RGB_RED   = 12'hF00;
    localparam logic [11:0] RGB_GREEN = 12'h0F0;
    localparam logic [11:0] RGB_BLUE  = 12'h00F;

    function automatic logic [11:0] col_to_rgb(input logic [1:0] code);
        logic [11:0] rgb;
        case (cell_col_e'(code))
            COL_EMPTY: rgb = RGB_EMPTY;
            COL_RED:   rgb = RGB_RED;
            COL_GREEN: rgb = RGB_GREEN;
            COL_BLUE:  rgb = RGB_BLUE;
            default:   rgb = RGB_EMPTY;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_grid_renderer_if.sv
// Bus between the game controller (grid source) and the renderer, which
// drives the VGA pins. master = renderer side, slave = its environment.
interface vga_grid_renderer_if #(
    parameter int GRID_W = snake_vga_pkg::GRID_W,
    parameter int GRID_H = snake_vga_pkg::GRID_H
);
    logic [GRID_W*GRID_H*2-1:0] grid_flat;
    logic                       vga_hs;
    logic                       vga_vs;
    logic [3:0]                 vga_r;
    logic [3:0]                 vga_g;
    logic [3:0]                 vga_b;
    logic                       frame_tick;
    logic [9:0]                 pix_x;
    logic [9:0]                 pix_y;

    modport master (
        input  grid_flat,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_tick, pix_x, pix_y
    );

    modport slave (
        output grid_flat,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_tick, pix_x, pix_y
    );
endinterface

// File: rtl/vga_grid_renderer_timing.sv
// Pixel enable, h/v raster counters, per-cell sub-counters and the
// combinational sync / visible / snapshot decodes of the current state.
module vga_timing #(
    parameter int H_VISIBLE = snake_vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = snake_vga_pkg::H_FRONT,
    parameter int H_SYNC    = snake_vga_pkg::H_SYNC,
    parameter int H_BACK    = snake_vga_pkg::H_BACK,
    parameter int V_VISIBLE = snake_vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = snake_vga_pkg::V_FRONT,
    parameter int V_SYNC    = snake_vga_pkg::V_SYNC,
    parameter int V_BACK    = snake_vga_pkg::V_BACK,
    parameter int CELL_PX   = snake_vga_pkg::CELL_PX
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pe,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic [9:0] cx,
    output logic [9:0] cy,
    output logic       visible,
    output logic       hs_n,
    output logic       vs_n,
    output logic       snap
);
    localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] CELL_LAST = 10'(CELL_PX - 1);

    logic       pe_r;
    logic [9:0] h_r;
    logic [9:0] v_r;
    logic [9:0] subx_r;
    logic [9:0] cx_r;
    logic [9:0] suby_r;
    logic [9:0] cy_r;

    // Raster and cell counters; cells are tracked by sub-counters so no divider is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pe_r   <= 1'b1;
            h_r    <= 10'd0;
            v_r    <= 10'd0;
            subx_r <= 10'd0;
            cx_r   <= 10'd0;
            suby_r <= 10'd0;
            cy_r   <= 10'd0;
        end else begin
            pe_r <= ~pe_r;
            if (pe_r) begin
                if (h_r == H_LAST) begin
                    h_r    <= 10'd0;
                    subx_r <= 10'd0;
                    cx_r   <= 10'd0;
                    if (v_r == V_LAST) begin
                        v_r    <= 10'd0;
                        suby_r <= 10'd0;
                        cy_r   <= 10'd0;
                    end else begin
                        v_r <= v_r + 10'd1;
                        if (suby_r == CELL_LAST) begin
                            suby_r <= 10'd0;
                            cy_r   <= cy_r + 10'd1;
                        end else begin
                            suby_r <= suby_r + 10'd1;
                        end
                    end
                end else begin
                    h_r <= h_r + 10'd1;
                    if (subx_r == CELL_LAST) begin
                        subx_r <= 10'd0;
                        cx_r   <= cx_r + 10'd1;
                    end else begin
                        subx_r <= subx_r + 10'd1;
                    end
                end
            end
        end
    end

    assign pe      = pe_r;
    assign h       = h_r;
    assign v       = v_r;
    assign cx      = cx_r;
    assign cy      = cy_r;
    assign visible = (h_r < H_VIS) && (v_r < V_VIS);
    assign hs_n    = !((h_r >= HS_START) && (h_r < HS_END));
    assign vs_n    = !((v_r >= VS_START) && (v_r < VS_END));
    assign snap    = pe_r && (h_r == 10'd0) && (v_r == V_VIS);

endmodule

// File: rtl/vga_grid_renderer.sv
// Renders the two-bit cell grid as 640x480 VGA. The grid is latched into a
// shadow copy at vblank start so a frame is always drawn from one snapshot.
module vga_grid_renderer #(
    parameter int H_VISIBLE = snake_vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = snake_vga_pkg::H_FRONT,
    parameter int H_SYNC    = snake_vga_pkg::H_SYNC,
    parameter int H_BACK    = snake_vga_pkg::H_BACK,
    parameter int V_VISIBLE = snake_vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = snake_vga_pkg::V_FRONT,
    parameter int V_SYNC    = snake_vga_pkg::V_SYNC,
    parameter int V_BACK    = snake_vga_pkg::V_BACK,
    parameter int CELL_PX   = snake_vga_pkg::CELL_PX,
    parameter int GRID_W    = snake_vga_pkg::GRID_W,
    parameter int GRID_H    = snake_vga_pkg::GRID_H
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_grid_renderer_if.master  bus
);
    import snake_vga_pkg::*;

    localparam int CELLS     = GRID_W * GRID_H;
    localparam int GRID_BITS = CELLS * 2;
    localparam int IDX_W     = $clog2(GRID_BITS);

    logic                 pe_s;
    logic [9:0]           h_s;
    logic [9:0]           v_s;
    logic [9:0]           cx_s;
    logic [9:0]           cy_s;
    logic                 vis_s;
    logic                 hs_n_s;
    logic                 vs_n_s;
    logic                 snap_s;

    logic [GRID_BITS-1:0] shadow_r;
    logic [11:0]          rgb_r;
    logic                 hs_r;
    logic                 vs_r;
    logic                 tick_r;
    logic [9:0]           pix_x_r;
    logic [9:0]           pix_y_r;

    int                   cell_idx_s;
    logic [IDX_W-1:0]     bit_idx_s;
    logic [1:0]           code_s;
    logic [11:0]          pix_rgb_s;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .CELL_PX   (CELL_PX)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .pe      (pe_s),
        .h       (h_s),
        .v       (v_s),
        .cx      (cx_s),
        .cy      (cy_s),
        .visible (vis_s),
        .hs_n    (hs_n_s),
        .vs_n    (vs_n_s),
        .snap    (snap_s)
    );

    // Shadow cell lookup for the current raster position; blank outside the picture.
    always_comb begin
        cell_idx_s = int'(cy_s) * GRID_W + int'(cx_s);
        bit_idx_s  = IDX_W'(cell_idx_s * 2);
        if (vis_s && (cell_idx_s < CELLS)) begin
            code_s = shadow_r[bit_idx_s +: 2];
        end else begin
            code_s = COL_EMPTY;
        end
        pix_rgb_s = col_to_rgb(code_s);
    end

    // Output registers share one pe edge so sync, colour and position never skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r <= {GRID_BITS{1'b0}};
            rgb_r    <= RGB_EMPTY;
            hs_r     <= 1'b1;
            vs_r     <= 1'b1;
            tick_r   <= 1'b0;
            pix_x_r  <= 10'd0;
            pix_y_r  <= 10'd0;
        end else begin
            tick_r <= snap_s;
            if (pe_s) begin
                hs_r    <= hs_n_s;
                vs_r    <= vs_n_s;
                pix_x_r <= h_s;
                pix_y_r <= v_s;
                rgb_r   <= pix_rgb_s;
            end
            if (snap_s) begin
                shadow_r <= bus.grid_flat;
            end
        end
    end

    assign bus.vga_hs     = hs_r;
    assign bus.vga_vs     = vs_r;
    assign bus.vga_r      = rgb_r[11:8];
    assign bus.vga_g      = rgb_r[7:4];
    assign bus.vga_b      = rgb_r[3:0];
    assign bus.frame_tick = tick_r;
    assign bus.pix_x      = pix_x_r;
    assign bus.pix_y      = pix_y_r;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Directed bench: dut0 uses the full 640x480 timing for reset and line
// checks; dut1 uses a shrunken raster (4x3 cells of 10 px) for frame-level checks.
module tb_vga_grid_renderer;

    // Small raster: H total 54, V total 36, frame 1944 pixels, vblank at k=30*54
    localparam int SH_TOT   = 54;
    localparam int SV_TOT   = 36;
    localparam int S_FRAME  = SH_TOT * SV_TOT;
    localparam int S_TICK_K = 30 * SH_TOT;
    localparam int S_FCLK   = 2 * S_FRAME;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic reset0;
    logic reset1;

    vga_grid_renderer_if if0 ();
    vga_grid_renderer_if #(.GRID_W(4), .GRID_H(3)) if1 ();

    vga_grid_renderer dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (if0)
    );

    vga_grid_renderer #(
        .H_VISIBLE (40), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
        .V_VISIBLE (30), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
        .CELL_PX   (10), .GRID_W  (4), .GRID_H (3)
    ) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (if1)
    );

    logic [11:0] rgb0;
    logic [11:0] rgb1;
    assign rgb0 = {if0.vga_r, if0.vga_g, if0.vga_b};
    assign rgb1 = {if1.vga_r, if1.vga_g, if1.vga_b};

    int tests_run    = 0;
    int tests_failed = 0;
    int c0, c1, d, k, mh, mv, tick_seen, t, n;
    logic [23:0] gm;
    logic        eft;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input logic [1:0] code);
        case (code)
            2'b00:   return 12'h000;
            2'b01:   return 12'hF00;
            2'b10:   return 12'h0F0;
            2'b11:   return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // One clock of dut1 checked against the raster/shadow model.
    task automatic step();
        logic [1:0]  code;
        logic [34:0] obs;
        logic [34:0] exp;
        @(negedge clk);
        d   = cyc - c1;
        k   = d / 2;
        mh  = k % SH_TOT;
        mv  = (k / SH_TOT) % SV_TOT;
        eft = (d % 2 == 0) && (k % S_FRAME == S_TICK_K);
        if (eft) gm = if1.grid_flat;
        code = 2'b00;
        if (mh < 40 && mv < 30) code = 2'(gm >> (2 * ((mv / 10) * 4 + mh / 10)));
        exp = {(mh < 44 || mh >= 50), (mv < 32 || mv >= 34), exp_rgb(code), eft,
               10'(mh), 10'(mv)};
        obs = {if1.vga_hs, if1.vga_vs, rgb1, if1.frame_tick, if1.pix_x, if1.pix_y};
        if (if1.frame_tick) tick_seen++;
        check($sformatf("scan(h=%0d,v=%0d)", mh, mv), 64'(obs), 64'(exp));
    endtask

    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) step();
    endtask

    task automatic run_until(input int th, input int tv);
        int m;
        m = 0;
        do begin
            step();
            m++;
        end while (!(mh == th && mv == tv && d % 2 == 0) && m < S_FCLK + 8);
        if (m >= S_FCLK + 8) begin
            tests_run++;
            tests_failed++;
            $error("FAIL run_until(%0d,%0d): not reached within %0d clks", th, tv, m);
        end
    endtask

    initial begin
        reset0 = 1'b1;
        reset1 = 1'b1;
        if0.grid_flat = '0;
        if1.grid_flat = 24'hFFFFFF;
        gm = 24'h000000;
        c1 = 0;
        tick_seen = 0;

        // Reset held: sync idle, colour black even with a non-zero grid
        repeat (100) begin
            @(negedge clk);
            check("rst_hs", 64'(if0.vga_hs), 64'd1);
            check("rst_vs", 64'(if0.vga_vs), 64'd1);
            check("rst_rgb", 64'(rgb0), 64'd0);
            check("rst_rgb_small", 64'(rgb1), 64'd0);
        end

        reset0 = 1'b0;
        c0 = cyc + 1;
        @(negedge clk);
        check("pix_x_clk1", 64'(if0.pix_x), 64'd0);
        @(negedge clk);
        check("pix_x_clk2", 64'(if0.pix_x), 64'd0);
        @(negedge clk);
        check("pix_x_clk3", 64'(if0.pix_x), 64'd1);
        check("pix_y_clk3", 64'(if0.pix_y), 64'd0);

        while (if0.vga_hs === 1'b1 && cyc - c0 < 4000) @(negedge clk);
        check("hs_fall", 64'(cyc - c0), 64'd1312);
        t = cyc;
        while (if0.vga_hs === 1'b0 && cyc - t < 4000) @(negedge clk);
        check("hs_low", 64'(cyc - t), 64'd192);
        while (if0.pix_x !== 10'd0 && cyc - c0 < 4000) @(negedge clk);
        check("line_period", 64'(cyc - c0), 64'd1600);
        check("line_y", 64'(if0.pix_y), 64'd1);
        check("line_vs", 64'(if0.vga_vs), 64'd1);

        // Small raster: first frame black, then all-green frame
        if1.grid_flat = 24'hAAAAAA;
        reset1 = 1'b0;
        c1 = cyc + 1;
        run(3240 + S_FCLK);

        // Only cell (1,0) red
        if1.grid_flat = 24'h000004;
        run_until(9, 0);
        check("cell_x9", 64'(rgb1), 64'h000);
        run_until(10, 0);
        check("cell_x10", 64'(rgb1), 64'hF00);
        run_until(19, 9);
        check("cell_x19y9", 64'(rgb1), 64'hF00);
        run_until(20, 9);
        check("cell_x20", 64'(rgb1), 64'h000);
        run_until(10, 10);
        check("cell_y10", 64'(rgb1), 64'h000);

        // Blue snapshot, grid changes mid-frame to red
        if1.grid_flat = 24'hFFFFFF;
        run_until(0, 30);
        check("tick_blue", 64'(if1.frame_tick), 64'd1);
        run_until(0, 15);
        if1.grid_flat = 24'h555555;
        tick_seen = 0;
        run_until(5, 16);
        check("hold_blue", 64'(rgb1), 64'h00F);
        run_until(0, 31);
        check("one_tick", 64'(tick_seen), 64'd1);
        run_until(5, 16);
        check("next_red", 64'(rgb1), 64'hF00);

        // One-clock reset mid-frame
        run_until(30, 20);
        reset1 = 1'b1;
        @(negedge clk);
        check("mid_rst_hs", 64'(if1.vga_hs), 64'd1);
        check("mid_rst_vs", 64'(if1.vga_vs), 64'd1);
        check("mid_rst_rgb", 64'(rgb1), 64'd0);
        check("mid_rst_tick", 64'(if1.frame_tick), 64'd0);
        check("mid_rst_px", 64'(if1.pix_x), 64'd0);
        check("mid_rst_py", 64'(if1.pix_y), 64'd0);
        reset1 = 1'b0;
        c1 = cyc + 1;
        gm = 24'h000000;
        tick_seen = 0;
        run_until(5, 16);
        check("post_rst_black", 64'(rgb1), 64'h000);
        n = 0;
        while (tick_seen == 0 && n < 5000) begin
            step();
            n++;
        end
        check("tick_delay", 64'(cyc - c1), 64'd3240);
        run_until(5, 16);
        check("red_after_rst", 64'(rgb1), 64'hF00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
